sram_rmw_ctrl: RTL

SRAM_RMW_CTRL -- requirements
Module: sram_rmw_ctrl

---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_byte_merge.sv | 22 ++
 rtl/sram_rmw_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared widths and controller state encoding for the SRAM
// read-modify-write controller.
package sram_ctrl_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RSP
    } state_e;

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-lane merge: each selected lane takes the new byte,
// every other lane keeps the old byte.
module sram_byte_merge
    import sram_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] merged
);

    // Overlay the selected new bytes onto the old word
    always_comb begin
        merged = old_word;
        for (int n = 0; n < SEL_W; n++) begin
            if (sel[n]) begin
                merged[8*n +: 8] = new_word[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Single-request SRAM controller: reads, full writes and
// byte-masked writes via read-modify-write; all outputs registered.
module sram_rmw_ctrl
    import sram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    // Holds the read word or the word written; doubles as rsp_rdata
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              sram_en_q, sram_en_d;
    logic              sram_wen_q, sram_wen_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0] merged;

    sram_byte_merge u_merge (
        .old_word (sram_rdata),
        .new_word (wdata_q),
        .sel      (sel_q),
        .merged   (merged)
    );

    // Next-state, request latch and next registered outputs
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    sel_d   = req_sel;
                    wdata_d = req_wdata;
                    if (!req_we) begin
                        state_d = RD;
                    end else if (req_sel == '0) begin
                        data_d  = '0;
                        state_d = RSP;
                    end else if (req_sel == '1) begin
                        data_d  = req_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (we_q) begin
                    data_d  = merged;
                    state_d = WR;
                end else begin
                    data_d  = sram_rdata;
                    state_d = RSP;
                end
            end
            WR:  state_d = RSP;
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // SRAM bus is zero whenever no access is being made
        req_ready_d  = (state_d == IDLE);
        rsp_valid_d  = (state_d == RSP);
        sram_en_d    = (state_d == RD) || (state_d == WR);
        sram_wen_d   = (state_d == WR);
        sram_addr_d  = sram_en_d ? addr_d : '0;
        sram_wdata_d = sram_wen_d ? data_d : '0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_wen_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            sram_en_q    <= sram_en_d;
            sram_wen_q   <= sram_wen_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = data_q;
    assign sram_en    = sram_en_q;
    assign sram_wen   = sram_wen_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule
